lsu_mem_requester: RTL and testbench

- Pipeline-side initiator for the data memory: accepts one load/store op per transaction from the MEM stage.
- Drives the memory request/mask/address/write-data interface and waits for the memory's registered valid on loads.
- Returns byte/halfword-aligned, sign- or zero-extended load data.
- Stalls the pipeline via op_ready while busy, and reports misaligned, illegal and timeout errors.

---
 rtl/lsu_mem_requester_pkg.sv | 42 ++++
 rtl/lsu_mem_requester_if.sv | 39 +++
 rtl/lsu_mem_requester_load_align.sv | 27 ++
 rtl/lsu_mem_requester.sv | 169 ++++++++++++++++
 tb/tb_lsu_mem_requester.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_requester_pkg.sv
// Shared constants and lane helpers for the LSU memory requester.
// The funct3 codes, state codes and exception codes live here so the writeback path can reuse them.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_STORE = 2'd1;
   localparam state_t ST_LOAD  = 2'd2;
   localparam state_t ST_WAIT  = 2'd3;

   localparam logic [1:0] EXC_NONE     = 2'b00;
   localparam logic [1:0] EXC_MISALIGN = 2'b01;
   localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
   localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

   // size is funct3[1:0]: 0 byte, 1 half, 2 word
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'd0:    return 4'b0001 << off;
         2'd1:    return 4'b0011 << {off[1], 1'b0};
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         2'd0:    return {4{wdata[7:0]}};
         2'd1:    return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_requester_if.sv
// Pipeline op/response and data-memory bus bundle for the LSU requester.
// The master modport is the requester itself; slave is the pipeline plus memory around it.
interface lsu_mem_requester_if #(
   parameter int ADDR_W = 8
);
   logic              op_valid;
   logic              op_ready;
   logic              op_load;
   logic              op_store;
   logic [2:0]        op_funct3;
   logic [31:0]       op_addr;
   logic [31:0]       op_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              exc_valid;
   logic [1:0]        exc_code;
   logic              mem_request;
   logic              mem_we_re;
   logic              mem_load;
   logic [3:0]        mem_mask;
   logic [ADDR_W-1:0] mem_address;
   logic [31:0]       mem_data_in;
   logic              mem_valid;
   logic [31:0]       mem_data_out;

   modport master (
      input  op_valid, op_load, op_store, op_funct3, op_addr, op_wdata,
      output op_ready, resp_valid, resp_rdata, exc_valid, exc_code,
      output mem_request, mem_we_re, mem_load, mem_mask, mem_address, mem_data_in,
      input  mem_valid, mem_data_out
   );

   modport slave (
      output op_valid, op_load, op_store, op_funct3, op_addr, op_wdata,
      input  op_ready, resp_valid, resp_rdata, exc_valid, exc_code,
      input  mem_request, mem_we_re, mem_load, mem_mask, mem_address, mem_data_in,
      output mem_valid, mem_data_out
   );
endinterface

// File: rtl/lsu_mem_requester_load_align.sv
// Combinational load-data extractor: picks the byte/half at the latched offset and extends it.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[{offset, 3'b000} +: 8];
      half_sel = word[{offset[1], 4'b0000} +: 16];
      case (funct3)
         F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  data = {24'd0, byte_sel};
         F3_LH:   data = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  data = {16'd0, half_sel};
         F3_LW:   data = word;
         default: data = 32'd0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_requester.sv
// LSU memory requester: accepts one load/store op, drives the registered memory bus,
// waits for read data on loads and returns extended data or a misaligned/illegal/timeout error.
module lsu_mem_requester
   import lsu_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   lsu_mem_requester_if.master bus
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        offset_q, offset_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              mem_request_q, mem_request_d;
   logic              mem_we_re_q, mem_we_re_d;
   logic              mem_load_q, mem_load_d;
   logic [3:0]        mem_mask_q, mem_mask_d;
   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic [31:0]       mem_data_in_q, mem_data_in_d;
   logic              resp_valid_q, resp_valid_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;
   logic              exc_valid_q, exc_valid_d;
   logic [1:0]        exc_code_q, exc_code_d;

   logic              op_illegal;
   logic              op_misaligned;
   logic [31:0]       load_data;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^bus.op_addr[31:ADDR_W+2];

   lsu_load_align u_align (
      .word   (bus.mem_data_out),
      .offset (offset_q),
      .funct3 (funct3_q),
      .data   (load_data)
   );

   always_comb begin
      op_illegal = (bus.op_load == bus.op_store) ||
                   (bus.op_load && ((bus.op_funct3 == 3'd3) || (bus.op_funct3[2:1] == 2'b11))) ||
                   (bus.op_store && (bus.op_funct3 >= 3'd3));
      op_misaligned = ((bus.op_funct3[1:0] == 2'd1) && bus.op_addr[0]) ||
                      ((bus.op_funct3[1:0] == 2'd2) && (bus.op_addr[1:0] != 2'b00));
   end

   always_comb begin
      state_d       = state_q;
      funct3_d      = funct3_q;
      offset_d      = offset_q;
      cnt_d         = cnt_q;
      mem_request_d = 1'b0;
      mem_we_re_d   = 1'b0;
      mem_load_d    = 1'b0;
      mem_mask_d    = mem_mask_q;
      mem_address_d = mem_address_q;
      mem_data_in_d = mem_data_in_q;
      resp_valid_d  = 1'b0;
      resp_rdata_d  = 32'd0;
      exc_valid_d   = 1'b0;
      exc_code_d    = EXC_NONE;

      case (state_q)
         ST_IDLE: begin
            if (bus.op_valid) begin
               funct3_d      = bus.op_funct3;
               offset_d      = bus.op_addr[1:0];
               mem_mask_d    = lane_mask(bus.op_funct3[1:0], bus.op_addr[1:0]);
               mem_address_d = bus.op_addr[ADDR_W+1:2];
               mem_data_in_d = lane_data(bus.op_funct3[1:0], bus.op_wdata);
               if (op_illegal) begin
                  exc_valid_d = 1'b1;
                  exc_code_d  = EXC_ILLEGAL;
               end else if (op_misaligned) begin
                  exc_valid_d = 1'b1;
                  exc_code_d  = EXC_MISALIGN;
               end else if (bus.op_store) begin
                  // A store completes in its single bus cycle, so the response rides along with it
                  state_d       = ST_STORE;
                  mem_request_d = 1'b1;
                  mem_we_re_d   = 1'b1;
                  resp_valid_d  = 1'b1;
               end else begin
                  state_d       = ST_LOAD;
                  mem_request_d = 1'b1;
                  mem_load_d    = 1'b1;
                  cnt_d         = 8'd0;
               end
            end
         end
         ST_STORE: begin
            state_d = ST_IDLE;
         end
         ST_LOAD: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Data arriving on the last allowed cycle still beats the timeout
            if (bus.mem_valid) begin
               state_d      = ST_IDLE;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_data;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d     = ST_IDLE;
               exc_valid_d = 1'b1;
               exc_code_d  = EXC_TIMEOUT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         funct3_q      <= 3'd0;
         offset_q      <= 2'd0;
         cnt_q         <= 8'd0;
         mem_request_q <= 1'b0;
         mem_we_re_q   <= 1'b0;
         mem_load_q    <= 1'b0;
         mem_mask_q    <= 4'd0;
         mem_address_q <= '0;
         mem_data_in_q <= 32'd0;
         resp_valid_q  <= 1'b0;
         resp_rdata_q  <= 32'd0;
         exc_valid_q   <= 1'b0;
         exc_code_q    <= EXC_NONE;
      end else begin
         state_q       <= state_d;
         funct3_q      <= funct3_d;
         offset_q      <= offset_d;
         cnt_q         <= cnt_d;
         mem_request_q <= mem_request_d;
         mem_we_re_q   <= mem_we_re_d;
         mem_load_q    <= mem_load_d;
         mem_mask_q    <= mem_mask_d;
         mem_address_q <= mem_address_d;
         mem_data_in_q <= mem_data_in_d;
         resp_valid_q  <= resp_valid_d;
         resp_rdata_q  <= resp_rdata_d;
         exc_valid_q   <= exc_valid_d;
         exc_code_q    <= exc_code_d;
      end
   end

   assign bus.op_ready    = (state_q == ST_IDLE);
   assign bus.mem_request = mem_request_q;
   assign bus.mem_we_re   = mem_we_re_q;
   assign bus.mem_load    = mem_load_q;
   assign bus.mem_mask    = mem_mask_q;
   assign bus.mem_address = mem_address_q;
   assign bus.mem_data_in = mem_data_in_q;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_rdata  = resp_rdata_q;
   assign bus.exc_valid   = exc_valid_q;
   assign bus.exc_code    = exc_code_q;

endmodule

// File: tb/tb_lsu_mem_requester.sv
// Self-checking bench for lsu_mem_requester: directed plan items, then random ops against a byte-level model.
module tb_lsu_mem_requester;
   import lsu_pkg::*;

   localparam int ADDR_W  = 8;
   localparam int TIMEOUT = 15;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   lsu_mem_requester_if #(.ADDR_W(ADDR_W)) bus();

   lsu_mem_requester #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference model: access size in bytes from the low funct3 bits
   function automatic int unsigned op_size(input logic [2:0] f3);
      return 32'd1 << f3[1:0];
   endfunction

   function automatic logic [1:0] model_exc(input logic ld, input logic st,
                                            input logic [2:0] f3, input logic [31:0] addr);
      if (ld == st) return 2'b10;
      if (ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 2'b10;
      if (st && f3 >= 3'd3) return 2'b10;
      if ((addr % op_size(f3)) != 0) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [31:0] addr);
      int unsigned m;
      m = ((32'd1 << op_size(f3)) - 1) << (addr % 4);
      return m[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wdata);
      logic [31:0] r;
      int unsigned sz;
      sz = op_size(f3);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % sz) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] word);
      longint unsigned v;
      longint unsigned keep;
      int unsigned     sz;
      sz   = op_size(f3);
      keep = (64'd1 << (8 * sz)) - 1;
      v    = (64'(word) >> (8 * (addr % 4))) & keep;
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~keep;
      return v[31:0];
   endfunction

   task automatic apply_stimulus(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
      check_output("accept_op_ready", bus.op_ready, 1);
      bus.op_valid  = 1'b1;
      bus.op_load   = ld;
      bus.op_store  = st;
      bus.op_funct3 = f3;
      bus.op_addr   = addr;
      bus.op_wdata  = wdata;
      tick;
      bus.op_valid  = 1'b0;
   endtask

   task automatic idle_gap;
      bus.mem_valid    = 1'($urandom_range(0, 1));
      bus.mem_data_out = $urandom;
      tick;
      bus.mem_valid = 1'b0;
      check_output("idle_resp_valid", bus.resp_valid, 0);
      check_output("idle_exc_valid", bus.exc_valid, 0);
      check_output("idle_op_ready", bus.op_ready, 1);
   endtask

   // Runs one op; wait_idx is the WAIT cycle carrying mem_valid (>= TIMEOUT withholds it).
   // Loads and errors end in their response cycle so the next op can follow back-to-back.
   task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] word, input int wait_idx);
      logic [1:0] exc;
      bit         done;
      exc = model_exc(ld, st, f3, addr);
      apply_stimulus(ld, st, f3, addr, wdata);
      if (exc != 2'b00) begin
         check_output("err_exc_valid", bus.exc_valid, 1);
         check_output("err_exc_code", bus.exc_code, exc);
         check_output("err_no_request", bus.mem_request, 0);
         check_output("err_resp_valid", bus.resp_valid, 0);
         check_output("err_op_ready", bus.op_ready, 1);
      end else if (st) begin
         check_output("st_request", bus.mem_request, 1);
         check_output("st_we_re", bus.mem_we_re, 1);
         check_output("st_mem_load", bus.mem_load, 0);
         check_output("st_mask", bus.mem_mask, model_mask(f3, addr));
         check_output("st_address", bus.mem_address, addr[ADDR_W+1:2]);
         check_output("st_data_in", bus.mem_data_in, model_wdata(f3, wdata));
         check_output("st_resp_valid", bus.resp_valid, 1);
         check_output("st_resp_rdata", bus.resp_rdata, 0);
         check_output("st_exc_valid", bus.exc_valid, 0);
         check_output("st_op_ready", bus.op_ready, 0);
         tick;
         check_output("st_done_op_ready", bus.op_ready, 1);
         check_output("st_done_resp", bus.resp_valid, 0);
         check_output("st_done_request", bus.mem_request, 0);
      end else begin
         check_output("ld_request", bus.mem_request, 1);
         check_output("ld_we_re", bus.mem_we_re, 0);
         check_output("ld_mem_load", bus.mem_load, 1);
         check_output("ld_mask", bus.mem_mask, model_mask(f3, addr));
         check_output("ld_address", bus.mem_address, addr[ADDR_W+1:2]);
         check_output("ld_op_ready", bus.op_ready, 0);
         check_output("ld_resp_valid", bus.resp_valid, 0);
         done = 1'b0;
         for (int i = 0; i < TIMEOUT && !done; i++) begin
            tick;
            check_output("wait_request", bus.mem_request, 0);
            check_output("wait_mem_load", bus.mem_load, 0);
            check_output("wait_resp_valid", bus.resp_valid, 0);
            check_output("wait_exc_valid", bus.exc_valid, 0);
            bus.op_valid     = 1'b1;
            bus.op_load      = 1'b0;
            bus.op_store     = 1'b1;
            bus.mem_valid    = (i == wait_idx);
            bus.mem_data_out = (i == wait_idx) ? word : $urandom;
            if (i == wait_idx) begin
               tick;
               bus.op_valid  = 1'b0;
               bus.mem_valid = 1'b0;
               check_output("ld_resp_pulse", bus.resp_valid, 1);
               check_output("ld_resp_rdata", bus.resp_rdata, model_load(f3, addr, word));
               check_output("ld_resp_no_exc", bus.exc_valid, 0);
               check_output("ld_resp_op_ready", bus.op_ready, 1);
               done = 1'b1;
            end
         end
         if (!done) begin
            tick;
            bus.op_valid  = 1'b0;
            bus.mem_valid = 1'b0;
            check_output("to_exc_valid", bus.exc_valid, 1);
            check_output("to_exc_code", bus.exc_code, 2'b11);
            check_output("to_resp_valid", bus.resp_valid, 0);
            check_output("to_op_ready", bus.op_ready, 1);
         end
      end
   endtask

   initial begin
      bit seen_exc;
      logic ld, st;
      logic [2:0] f3;
      logic [31:0] addr;
      int w;

      bus.op_valid     = 1'b0;
      bus.op_load      = 1'b0;
      bus.op_store     = 1'b0;
      bus.op_funct3    = 3'd0;
      bus.op_addr      = 32'd0;
      bus.op_wdata     = 32'd0;
      bus.mem_valid    = 1'b0;
      bus.mem_data_out = 32'd0;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #2;
      check_output("rst_op_ready", bus.op_ready, 1);
      check_output("rst_request", bus.mem_request, 0);
      check_output("rst_mask", bus.mem_mask, 0);
      check_output("rst_address", bus.mem_address, 0);
      check_output("rst_resp_valid", bus.resp_valid, 0);
      check_output("rst_exc_valid", bus.exc_valid, 0);
      tick;
      tick;
      rst = 1'b1;
      tick;

      $display("[TB] directed plan");
      run_op(1'b0, 1'b1, F3_SB,  32'h0000_0013, 32'h0000_00A5, 32'h0, 0);
      run_op(1'b1, 1'b0, F3_LB,  32'h0000_0021, 32'h0, 32'h1234_80FF, 0);
      run_op(1'b1, 1'b0, F3_LBU, 32'h0000_0021, 32'h0, 32'h1234_80FF, 0);
      run_op(1'b1, 1'b0, F3_LH,  32'h0000_0002, 32'h0, 32'h8001_7FFF, 0);
      run_op(1'b1, 1'b0, F3_LHU, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0);
      run_op(1'b1, 1'b0, F3_LW,  32'h0000_0006, 32'h0, 32'h0, 0);
      run_op(1'b1, 1'b1, F3_LW,  32'h0000_0004, 32'h0, 32'h0, 0);
      idle_gap;
      run_op(1'b1, 1'b0, F3_LW,  32'h0000_0040, 32'h0, 32'hDEAD_BEEF, TIMEOUT);
      run_op(1'b0, 1'b1, F3_SW,  32'h0000_0044, 32'hCAFE_F00D, 32'h0, 0);
      run_op(1'b1, 1'b0, F3_LW,  32'h0000_0048, 32'h0, 32'h0BAD_CAFE, TIMEOUT - 1);
      run_op(1'b1, 1'b0, F3_LH,  32'h0000_0003, 32'h0, 32'h0, 0);
      run_op(1'b0, 1'b1, F3_SH,  32'h0000_0036, 32'h0000_BEEF, 32'h0, 0);
      run_op(1'b0, 1'b1, 3'd3,   32'h0000_0000, 32'h0, 32'h0, 0);
      run_op(1'b0, 1'b0, F3_LB,  32'h0000_0000, 32'h0, 32'h0, 0);
      idle_gap;

      $display("[TB] reset during WAIT");
      apply_stimulus(1'b1, 1'b0, F3_LW, 32'h0000_0080, 32'h0);
      tick;
      tick;
      tick;
      rst = 1'b0;
      #1;
      check_output("mid_rst_op_ready", bus.op_ready, 1);
      check_output("mid_rst_request", bus.mem_request, 0);
      check_output("mid_rst_mem_load", bus.mem_load, 0);
      check_output("mid_rst_mask", bus.mem_mask, 0);
      check_output("mid_rst_address", bus.mem_address, 0);
      check_output("mid_rst_resp", bus.resp_valid, 0);
      check_output("mid_rst_exc", bus.exc_valid, 0);
      tick;
      rst = 1'b1;
      bus.mem_valid    = 1'b1;
      bus.mem_data_out = 32'h5555_AAAA;
      tick;
      bus.mem_valid = 1'b0;
      check_output("post_rst_resp", bus.resp_valid, 0);
      check_output("post_rst_op_ready", bus.op_ready, 1);
      seen_exc = 1'b0;
      for (int i = 0; i < TIMEOUT + 4; i++) begin
         tick;
         if (bus.exc_valid || bus.resp_valid) seen_exc = 1'b1;
      end
      check_output("post_rst_silent", seen_exc, 0);

      $display("[TB] random ops");
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 9))
            0:       begin ld = 1'b1; st = 1'b1; end
            1:       begin ld = 1'b0; st = 1'b0; end
            2, 3, 4: begin ld = 1'b0; st = 1'b1; end
            default: begin ld = 1'b1; st = 1'b0; end
         endcase
         f3   = 3'($urandom_range(0, 7));
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr = addr & ~(op_size(f3) - 1);
         w = ($urandom_range(0, 4) == 0) ? TIMEOUT : int'($urandom_range(0, TIMEOUT - 1));
         run_op(ld, st, f3, addr, $urandom, $urandom, w);
         if ($urandom_range(0, 1) != 0) idle_gap;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
